// File: rtl/pwm_cap_pkg.sv
// Shared definitions for the multi-channel RC pulse capture: channel FSM encoding,
// default sizes and the filter-length bound.
package pwm_cap_pkg;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      LOW       = 2'd2
   } ch_state_e;

   localparam int unsigned DEF_WIDTH         = 15;
   localparam int unsigned DEF_TIMEOUT_TICKS = 25000;
   localparam int unsigned FILT_LEN_MAX      = 8;

   // Bits needed to hold the values 0..max_val (at least one bit).
   function automatic int unsigned cnt_bits(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pwm_cap_chan.sv
// One capture channel: 2-flop synchroniser, run-length glitch filter, WAIT_RISE/HIGH/LOW
// FSM with saturating high counter, idle timeout and the latched width/valid/update flags.
module pwm_cap_chan
   import pwm_cap_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned FILT_LEN      = 3,
   parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_en,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] width_o,
   output logic             valid_o,
   output logic             upd_o,
   output logic             rise_o,
   output logic             timeout_o
);

   localparam int unsigned RW = cnt_bits(FILT_LEN);
   localparam int unsigned IW = cnt_bits(TIMEOUT_TICKS);
   localparam logic [RW-1:0]    RUN_FULL = RW'(FILT_LEN);
   localparam logic [IW-1:0]    IDLE_MAX = IW'(TIMEOUT_TICKS);
   localparam logic [WIDTH-1:0] CNT_MAX  = '1;

   logic [1:0]       sync_q, sync_d;
   logic [1:0]       fill_q, fill_d;
   logic             prev_q, prev_d;
   logic [RW-1:0]    run_q, run_d;
   logic             primed_q, primed_d;
   logic             filt_q, filt_d;
   ch_state_e        state_q, state_d;
   logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [WIDTH-1:0] width_q, width_d;
   logic             valid_q, valid_d;
   logic             upd_q, upd_d;
   logic             rise, fall, meas_fall, timeout;

   always_comb begin
      sync_d    = sync_q;
      fill_d    = fill_q;
      prev_d    = prev_q;
      run_d     = run_q;
      primed_d  = primed_q;
      filt_d    = filt_q;
      state_d   = state_q;
      hi_cnt_d  = hi_cnt_q;
      idle_d    = idle_q;
      width_d   = width_q;
      valid_d   = valid_q;
      upd_d     = 1'b0;
      rise      = 1'b0;
      fall      = 1'b0;
      meas_fall = 1'b0;
      timeout   = 1'b0;
      if (tick_en) begin
         sync_d = {sync_q[0], pwm_in};
         fill_d = {fill_q[0], 1'b1};
         // The first settled level after reset primes the filter without an edge,
         // so a pulse already high at reset release is never measured.
         if (fill_q[1]) begin
            if (sync_q[1] == prev_q && run_q != '0)
               run_d = (run_q == RUN_FULL) ? run_q : run_q + 1'b1;
            else
               run_d = RW'(1);
            prev_d = sync_q[1];
            if (run_d == RUN_FULL) begin
               if (!primed_q) begin
                  primed_d = 1'b1;
                  filt_d   = sync_q[1];
               end else if (sync_q[1] != filt_q) begin
                  filt_d = sync_q[1];
                  rise   = sync_q[1];
                  fall   = ~sync_q[1];
               end
            end
         end

         case (state_q)
            WAIT_RISE, LOW: begin
               if (rise) begin
                  state_d  = HIGH;
                  hi_cnt_d = WIDTH'(1);
               end
            end
            HIGH: begin
               if (fall) begin
                  state_d   = LOW;
                  width_d   = hi_cnt_q;
                  valid_d   = (hi_cnt_q != CNT_MAX);
                  upd_d     = 1'b1;
                  meas_fall = 1'b1;
               end else if (hi_cnt_q != CNT_MAX) begin
                  hi_cnt_d = hi_cnt_q + 1'b1;
               end
            end
            default: state_d = WAIT_RISE;
         endcase

         // A measured falling edge on the timeout tick takes priority.
         if (meas_fall) begin
            idle_d = '0;
         end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
            if (idle_q == IDLE_MAX - 1'b1) begin
               timeout = 1'b1;
               valid_d = 1'b0;
               state_d = WAIT_RISE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         fill_q   <= '0;
         prev_q   <= 1'b0;
         run_q    <= '0;
         primed_q <= 1'b0;
         filt_q   <= 1'b0;
         state_q  <= WAIT_RISE;
         hi_cnt_q <= '0;
         idle_q   <= '0;
         width_q  <= '0;
         valid_q  <= 1'b0;
         upd_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         fill_q   <= fill_d;
         prev_q   <= prev_d;
         run_q    <= run_d;
         primed_q <= primed_d;
         filt_q   <= filt_d;
         state_q  <= state_d;
         hi_cnt_q <= hi_cnt_d;
         idle_q   <= idle_d;
         width_q  <= width_d;
         valid_q  <= valid_d;
         upd_q    <= upd_d;
      end
   end

   assign width_o   = width_q;
   assign valid_o   = valid_q;
   assign upd_o     = upd_q;
   assign rise_o    = rise;
   assign timeout_o = timeout;

endmodule

// File: rtl/pwm_cap_rc_multi.sv
// N-channel RC receiver pulse capture with period measurement on one channel.
// Define PWM_CAP_FAILSAFE_EN to substitute FAILSAFE_WIDTH on channels without a valid measurement.
module pwm_cap_rc_multi
   import pwm_cap_pkg::*;
#(
   parameter int unsigned NUM_CH         = 8,
   parameter int unsigned WIDTH          = DEF_WIDTH,
   parameter int unsigned FILT_LEN       = 3,
   parameter int unsigned TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS,
   parameter int unsigned PERIOD_CH      = 0,
   parameter int unsigned FAILSAFE_WIDTH = 1500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tick_en,
   input  logic [NUM_CH-1:0]       pwm_in,
   output logic [NUM_CH*WIDTH-1:0] pulse_width,
   output logic [WIDTH-1:0]        pulse_period,
   output logic [NUM_CH-1:0]       ch_valid,
   output logic [NUM_CH-1:0]       width_upd,
   output logic                    sig_lost
);

`ifdef PWM_CAP_FAILSAFE_EN
   localparam bit FS_EN = 1'b1;
`else
   localparam bit FS_EN = 1'b0;
`endif
   localparam logic [WIDTH-1:0]  FS_VAL   = WIDTH'(FAILSAFE_WIDTH);
   localparam logic [NUM_CH-1:0] PER_MASK = NUM_CH'(1) << PERIOD_CH;
   localparam logic [WIDTH-1:0]  CNT_MAX  = '1;

   logic [NUM_CH*WIDTH-1:0] width_w;
   logic [NUM_CH-1:0]       rise_w, timeout_w;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         pwm_cap_chan #(
            .WIDTH         (WIDTH),
            .FILT_LEN      (FILT_LEN),
            .TIMEOUT_TICKS (TIMEOUT_TICKS)
         ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick_en   (tick_en),
            .pwm_in    (pwm_in[gi]),
            .width_o   (width_w[gi*WIDTH +: WIDTH]),
            .valid_o   (ch_valid[gi]),
            .upd_o     (width_upd[gi]),
            .rise_o    (rise_w[gi]),
            .timeout_o (timeout_w[gi])
         );
         assign pulse_width[gi*WIDTH +: WIDTH] =
            (FS_EN && !ch_valid[gi]) ? FS_VAL : width_w[gi*WIDTH +: WIDTH];
      end
   endgenerate

   logic             per_rise, per_tmo;
   logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             per_armed_q, per_armed_d;

   assign per_rise = |(rise_w & PER_MASK);
   assign per_tmo  = |(timeout_w & PER_MASK);

   // The first rising edge after reset or a timeout only arms the period counter.
   always_comb begin
      per_cnt_d   = per_cnt_q;
      period_d    = period_q;
      per_armed_d = per_armed_q;
      if (tick_en) begin
         if (per_tmo) begin
            per_armed_d = 1'b0;
         end else if (per_rise) begin
            if (per_armed_q)
               period_d = per_cnt_q;
            per_armed_d = 1'b1;
            per_cnt_d   = WIDTH'(1);
         end else if (per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt_q   <= '0;
         period_q    <= '0;
         per_armed_q <= 1'b0;
      end else begin
         per_cnt_q   <= per_cnt_d;
         period_q    <= period_d;
         per_armed_q <= per_armed_d;
      end
   end

   assign pulse_period = period_q;
   assign sig_lost     = ~|ch_valid;

endmodule

// File: tb/tb_pwm_cap_rc_multi.sv
// Directed bench for pwm_cap_rc_multi: expected widths are queued as pulses are driven and
// checked when width_upd fires; a second 8-bit instance covers counter overflow.
module tb_pwm_cap_rc_multi;

   localparam int NUM_CH = 8;
   localparam int WIDTH  = 15;
   localparam int FS     = 1500;
   localparam int FS8    = 200;
`ifdef PWM_CAP_FAILSAFE_EN
   localparam bit FS_ON = 1'b1;
`else
   localparam bit FS_ON = 1'b0;
`endif
   localparam int IDLE_W  = FS_ON ? FS : 0;
   localparam int OVF8_W  = FS_ON ? FS8 : 255;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst8_n = 1'b0;
   logic tick_en = 1'b1;
   logic [NUM_CH-1:0] pwm_in = '0;
   logic [1:0]        pwm8 = '0;

   logic [NUM_CH*WIDTH-1:0] pulse_width;
   logic [WIDTH-1:0]        pulse_period;
   logic [NUM_CH-1:0]       ch_valid, width_upd;
   logic                    sig_lost;
   logic [15:0]             pulse_width8;
   logic [7:0]              pulse_period8;
   logic [1:0]              ch_valid8, width_upd8;
   logic                    sig_lost8;

   int n_tests = 0;
   int n_fail = 0;
   int other_upd = 0;
   int exp_q[$];
   int exp8_q[$];

   always #5 clk = ~clk;

   pwm_cap_rc_multi #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .FILT_LEN(3), .TIMEOUT_TICKS(25000),
      .PERIOD_CH(0), .FAILSAFE_WIDTH(FS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .pwm_in(pwm_in),
      .pulse_width(pulse_width), .pulse_period(pulse_period), .ch_valid(ch_valid),
      .width_upd(width_upd), .sig_lost(sig_lost)
   );

   pwm_cap_rc_multi #(
      .NUM_CH(2), .WIDTH(8), .FILT_LEN(3), .TIMEOUT_TICKS(25000),
      .PERIOD_CH(0), .FAILSAFE_WIDTH(FS8)
   ) dut8 (
      .clk(clk), .rst_n(rst8_n), .tick_en(tick_en), .pwm_in(pwm8),
      .pulse_width(pulse_width8), .pulse_period(pulse_period8), .ch_valid(ch_valid8),
      .width_upd(width_upd8), .sig_lost(sig_lost8)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard pop on every width update.
   always @(negedge clk) begin
      if (width_upd[0]) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL upd0_spurious: width_upd[0] fired with width %0d, no update expected",
                   pulse_width[WIDTH-1:0]);
         end else begin
            check("upd0_width", int'(pulse_width[WIDTH-1:0]), exp_q.pop_front());
         end
      end
      if (width_upd8[0]) begin
         if (exp8_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL upd8_spurious: width_upd8[0] fired with width %0d, no update expected",
                   pulse_width8[7:0]);
         end else begin
            check("upd8_width", int'(pulse_width8[7:0]), exp8_q.pop_front());
         end
      end
      if (|width_upd[NUM_CH-1:1]) other_upd++;
   end

   initial begin
      bit seen;
      pwm_in[0] = 1'b1;
      step(5);
      check("rst_width0", int'(pulse_width[WIDTH-1:0]), IDLE_W);
      check("rst_width7", int'(pulse_width[7*WIDTH +: WIDTH]), IDLE_W);
      check("rst_period", int'(pulse_period), 0);
      check("rst_valid", int'(ch_valid), 0);
      check("rst_upd", int'(width_upd), 0);
      check("rst_lost", int'(sig_lost), 1);

      // Pulse high through reset release must not be measured.
      rst_n = 1'b1;
      rst8_n = 1'b1;
      step(700);
      pwm_in[0] = 1'b0;
      step(300);
      check("held_width", int'(pulse_width[WIDTH-1:0]), IDLE_W);
      check("held_valid", int'(ch_valid[0]), 0);

      exp_q.push_back(1000);
      pwm_in[0] = 1'b1; step(1000); pwm_in[0] = 1'b0; step(300);
      check("p1000_width", int'(pulse_width[WIDTH-1:0]), 1000);
      check("p1000_valid", int'(ch_valid[0]), 1);
      check("p1000_lost", int'(sig_lost), 0);

      // 2-tick glitch is filtered out.
      exp_q.push_back(1500);
      pwm_in[0] = 1'b1; step(700);
      pwm_in[0] = 1'b0; step(2);
      pwm_in[0] = 1'b1; step(798);
      pwm_in[0] = 1'b0; step(300);

      // 3-tick glitch splits the pulse.
      exp_q.push_back(700);
      exp_q.push_back(797);
      pwm_in[0] = 1'b1; step(700);
      pwm_in[0] = 1'b0; step(3);
      pwm_in[0] = 1'b1; step(797);
      pwm_in[0] = 1'b0; step(300);

      // tick_en gap of 50 clocks mid-pulse.
      exp_q.push_back(1000);
      pwm_in[0] = 1'b1; step(500);
      tick_en = 1'b0; step(50); tick_en = 1'b1;
      step(500);
      pwm_in[0] = 1'b0; step(300);

      // Frames of 20000 ticks with 1500-tick pulses.
      exp_q.push_back(1500);
      pwm_in[0] = 1'b1; step(1500); pwm_in[0] = 1'b0; step(10);
      check("period_first", int'(pulse_period), 1300);
      step(18490);
      exp_q.push_back(1500);
      pwm_in[0] = 1'b1; step(1500); pwm_in[0] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = width_upd[0];
      end
      check("frame_upd_seen", int'(seen), 1);
      check("period_frame", int'(pulse_period), 20000);
      check("frame_valid", int'(ch_valid[0]), 1);

      // No more input: timeout exactly 25000 ticks after the measured fall.
      step(24999);
      check("tmo_before_valid", int'(ch_valid[0]), 1);
      check("tmo_before_lost", int'(sig_lost), 0);
      step(1);
      check("tmo_at_valid", int'(ch_valid[0]), 0);
      check("tmo_at_lost", int'(sig_lost), 1);
      check("tmo_width0", int'(pulse_width[WIDTH-1:0]), 1500);
      check("tmo_width1", int'(pulse_width[WIDTH +: WIDTH]), IDLE_W);

      // Fresh measurement, then reset asserted mid-pulse.
      exp_q.push_back(400);
      pwm_in[0] = 1'b1; step(400); pwm_in[0] = 1'b0; step(50);
      check("re_valid", int'(ch_valid[0]), 1);
      pwm_in[0] = 1'b1; step(100);
      rst_n = 1'b0;
      #1;
      check("rmid_width0", int'(pulse_width[WIDTH-1:0]), IDLE_W);
      check("rmid_period", int'(pulse_period), 0);
      check("rmid_valid", int'(ch_valid), 0);
      check("rmid_upd", int'(width_upd), 0);
      check("rmid_lost", int'(sig_lost), 1);
      @(negedge clk);
      pwm_in[0] = 1'b0;
      rst_n = 1'b1;
      step(20);

      // 8-bit instance: normal pulse, then overflow.
      exp8_q.push_back(100);
      pwm8[0] = 1'b1; step(100); pwm8[0] = 1'b0; step(20);
      check("w8_valid", int'(ch_valid8[0]), 1);
      exp8_q.push_back(OVF8_W);
      pwm8[0] = 1'b1; step(300); pwm8[0] = 1'b0; step(20);
      check("w8_ovf_valid", int'(ch_valid8[0]), 0);
      check("w8_ovf_lost", int'(sig_lost8), 1);

      check("sb_main_empty", exp_q.size(), 0);
      check("sb_w8_empty", exp8_q.size(), 0);
      check("other_ch_upd", other_upd, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
